// File: rtl/booth_seq_pkg.sv
// Shared types and constants for the keypad-driven Booth multiplier sequencer.
package booth_seq_pkg;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        START,
        WAIT,
        SHOW,
        ERR
    } state_e;

    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam int         MAG_MAX   = 127;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic [7:0] to_twos(input logic [6:0] mag, input logic neg);
        logic [7:0] ext;
        ext = {1'b0, mag};
        return neg ? (~ext + 8'd1) : ext;
    endfunction

    // Operands never reach -128, so the magnitude always fits in 7 bits.
    function automatic logic [6:0] mag_of(input logic [7:0] v);
        return 7'(v[7] ? (~v + 8'd1) : v);
    endfunction

endpackage

// File: rtl/digit_accumulator.sv
// Decimal entry register (magnitude, digit count, sign) shared by operand A and B entry.
module digit_accumulator
    import booth_seq_pkg::*;
#(
    parameter int DIGITS_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       digit_valid_i,
    input  logic       sign_toggle_i,
    input  logic [3:0] digit_i,
    output logic [6:0] acc_o,
    output logic       neg_o
);

    localparam int CW = $clog2(DIGITS_MAX + 1);

    logic [6:0]    acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          neg_q, neg_d;
    logic [10:0]   cand;

    assign cand = 11'(acc_q) * 11'd10 + 11'(digit_i);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        acc_d   = acc_q;
        count_d = count_q;
        neg_d   = neg_q;
        if (clear_i) begin
            acc_d   = '0;
            count_d = '0;
            neg_d   = 1'b0;
        end else if (load_i) begin
            acc_d   = {3'b000, digit_i};
            count_d = CW'(1);
            neg_d   = 1'b0;
        end else if (digit_valid_i) begin
            if (count_q < CW'(DIGITS_MAX) && cand <= 11'(MAG_MAX)) begin
                acc_d   = cand[6:0];
                count_d = count_q + CW'(1);
            end
        end else if (sign_toggle_i) begin
            neg_d = ~neg_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            acc_q   <= acc_d;
            count_q <= count_d;
            neg_q   <= neg_d;
        end
    end

    assign acc_o = acc_q;
    assign neg_o = neg_q;

endmodule

// File: rtl/booth_sequencer.sv
// Keypad-to-Booth-multiplier sequencer: operand entry, start/wait handshake, result display.
// Optional WAIT timeout into ERR is enabled by defining MUL_TIMEOUT_EN.
module booth_sequencer
    import booth_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int DIGITS_MAX     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        mul_start,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic        mul_valid,
    input  logic [15:0] mul_y,
    output logic [15:0] disp_value,
    output logic        disp_neg,
    output logic        busy,
    output logic        error
);

    state_e      state_q, state_d;
    logic [15:0] res_q, res_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [15:0] disp_value_q, disp_value_d;
    logic        disp_neg_q, disp_neg_d;
    logic        mul_start_q, busy_q;

    logic       acc_clear, acc_load, acc_digit, acc_sign;
    logic [6:0] acc_mag;
    logic       acc_neg;

    logic key_clear, key_enter, key_sign, key_digit;
    assign key_clear = key_valid && key_code == KEY_CLEAR;
    assign key_enter = key_valid && key_code == KEY_ENTER;
    assign key_sign  = key_valid && key_code == KEY_SIGN;
    assign key_digit = key_valid && is_digit(key_code);

    digit_accumulator #(.DIGITS_MAX(DIGITS_MAX)) u_acc (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (acc_clear),
        .load_i        (acc_load),
        .digit_valid_i (acc_digit),
        .sign_toggle_i (acc_sign),
        .digit_i       (key_code),
        .acc_o         (acc_mag),
        .neg_o         (acc_neg)
    );

`ifdef MUL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= (state_q == WAIT) ? tmo_q + TW'(1) : '0;
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_clear = 1'b0;
        acc_load  = 1'b0;
        acc_digit = 1'b0;
        acc_sign  = 1'b0;
        // Clear wins over everything, including a coincident mul_valid.
        if (key_clear) begin
            state_d   = ENTER_A;
            res_d     = '0;
            a_d       = '0;
            b_d       = '0;
            acc_clear = 1'b1;
        end else begin
            unique case (state_q)
                ENTER_A, ENTER_B: begin
                    acc_digit = key_digit;
                    acc_sign  = key_sign;
                    if (key_enter) begin
                        acc_clear = 1'b1;
                        if (state_q == ENTER_A) begin
                            a_d     = to_twos(acc_mag, acc_neg);
                            state_d = ENTER_B;
                        end else begin
                            b_d     = to_twos(acc_mag, acc_neg);
                            state_d = START;
                        end
                    end
                end
                START: state_d = WAIT;
                WAIT: begin
                    if (mul_valid) begin
                        res_d   = mul_y;
                        state_d = SHOW;
                    end
`ifdef MUL_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = ERR;
                    end
`endif
                end
                SHOW: begin
                    if (key_digit) begin
                        acc_load = 1'b1;
                        state_d  = ENTER_A;
                    end
                end
                ERR:     state_d = ERR;
                default: state_d = ENTER_A;
            endcase
        end
    end

    always_comb begin
        disp_value_d = '0;
        disp_neg_d   = 1'b0;
        unique case (state_q)
            ENTER_A, ENTER_B: begin
                disp_value_d = {9'b0, acc_mag};
                disp_neg_d   = acc_neg && acc_mag != '0;
            end
            START, WAIT: begin
                disp_value_d = {9'b0, mag_of(b_q)};
                disp_neg_d   = b_q[7];
            end
            SHOW: begin
                disp_value_d = res_q[15] ? (~res_q + 16'd1) : res_q;
                disp_neg_d   = res_q[15];
            end
            default: begin
                disp_value_d = '0;
                disp_neg_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ENTER_A;
            res_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            disp_value_q <= '0;
            disp_neg_q   <= 1'b0;
            mul_start_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            a_q          <= a_d;
            b_q          <= b_d;
            disp_value_q <= disp_value_d;
            disp_neg_q   <= disp_neg_d;
            mul_start_q  <= state_d == START;
            busy_q       <= state_d == START || state_d == WAIT;
        end
    end

`ifdef MUL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) error_q <= 1'b0;
        else     error_q <= state_d == ERR;
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign mul_start  = mul_start_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign disp_value = disp_value_q;
    assign disp_neg   = disp_neg_q;
    assign busy       = busy_q;

endmodule

// File: doc/booth_sequencer.md
BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32: cycles allowed in WAIT before timeout (MUL_TIMEOUT_EN only).
REQ-002 SHALL have parameter DIGITS_MAX, default 3: maximum decimal digits per operand.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port key_valid  input  1  one-cycle debounced key event.
REQ-006 SHALL have port key_code  input  4  0-9 digit, 4'hA sign toggle, 4'hB enter, 4'hC clear, others ignored.
REQ-007 SHALL have port mul_start  output  1  one-cycle start pulse to the Booth multiplier.
REQ-008 SHALL have port mul_a  output  8  signed operand A, two's complement.
REQ-009 SHALL have port mul_b  output  8  signed operand B, two's complement.
REQ-010 SHALL have port mul_valid  input  1  multiplier result-valid pulse.
REQ-011 SHALL have port mul_y  input  16  signed product.
REQ-012 SHALL have port disp_value  output  16  unsigned magnitude for the BCD converter.
REQ-013 SHALL have port disp_neg  output  1  sign of the displayed value.
REQ-014 SHALL have port busy  output  1  high in START and WAIT.
REQ-015 SHALL have port error  output  1  high in ERR.

Function
REQ-016 SHALL implement states ENTER_A, ENTER_B, START, WAIT, SHOW, ERR.
REQ-017 In ENTER_A/ENTER_B, a digit d SHALL set acc=acc*10+d only if digit count<DIGITS_MAX and the result is <=127; otherwise the key is ignored.
REQ-018 In ENTER_A/ENTER_B, sign key SHALL toggle the operand sign; enter SHALL latch the two's-complement operand to mul_a/mul_b, clear acc/sign/count and advance (A->ENTER_B, B->START).
REQ-019 START SHALL assert mul_start for exactly one cycle, then go to WAIT; non-clear keys are ignored.
REQ-020 In WAIT, mul_valid SHALL latch mul_y into the result register and go to SHOW the next cycle.
REQ-021 In SHOW, a digit key SHALL go to ENTER_A with acc=d, sign positive; enter and sign keys are ignored.
REQ-022 Clear key SHALL, from any state, go to ENTER_A, zero acc, signs, result and mul_a/mul_b; clear beats mul_valid in the same cycle.
REQ-023 mul_valid outside WAIT SHALL be ignored.
REQ-024 disp_value/disp_neg SHALL show acc and its sign in entry states, |result| and result sign in SHOW, last entered operand B in START/WAIT, 0/0 in ERR.
REQ-025 Magnitude range SHALL be 0..127 (-128 not enterable); |product| <= 16129; -0 displays with disp_neg=0.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst SHALL asynchronously force state ENTER_A; acc, signs, count, result, mul_a, mul_b, disp_value = 0; mul_start, disp_neg, busy, error = 0.
REQ-028 Reset mid-WAIT SHALL abandon the operation; a subsequent mul_valid is ignored.

Configuration
REQ-029 With MUL_TIMEOUT_EN defined, a counter SHALL run in WAIT; if no mul_valid within TIMEOUT_CYCLES cycles of entering WAIT the FSM goes to ERR (error=1), exited only by clear; mul_valid on the final cycle wins.
REQ-030 Without MUL_TIMEOUT_EN, WAIT SHALL persist indefinitely, ERR is unreachable, error is tied 0, and no counter is synthesised.

Structure
REQ-031 Package booth_seq_pkg SHALL hold the state enum, key code constants (KEY_SIGN, KEY_ENTER, KEY_CLEAR) and MAG_MAX=127.
REQ-032 Sub-module digit_accumulator SHALL hold acc, count and sign; one instance is shared between A and B entry.

Verification
REQ-033 Keys 1,2,B,3,B; mul_valid 8 cycles after start with mul_y=36 -> one mul_start pulse, mul_a=12, mul_b=3, disp_value=36, disp_neg=0.
REQ-034 Keys A,5,B,7,B; mul_y=16'hFFDD -> mul_a=8'hFB, mul_b=8'h07, disp_value=35, disp_neg=1.
REQ-035 Keys 1,2,8 -> disp_value stays 12; the 4th digit after 1,0,0 is ignored.
REQ-036 Clear during WAIT, then mul_valid -> state ENTER_A, disp_value=0, result not latched.
REQ-037 MUL_TIMEOUT_EN, TIMEOUT_CYCLES=32, no mul_valid -> error=1 after 32 WAIT cycles; clear -> error=0, ENTER_A.
REQ-038 rst asserted mid-WAIT -> all outputs 0 immediately; later mul_valid has no effect.
